// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice: default address and
// data widths, the two memory-mapped I/O port addresses, and the state and
// owner enumerations used by dmem_arbiter and rr_arb2.
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 8;

  localparam logic [9:0] IN_PORT_ADDR  = 10'h3FE;
  localparam logic [9:0] OUT_PORT_ADDR = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick between the CPU and the DMA engine.
// On a tie the requester that did not own the previous access wins.
//
// Ports:
//   req_cpu      in   CPU request
//   req_dma      in   DMA request
//   last_owner   in   owner of the most recent completed access
//   grant_valid  out  at least one request present
//   grant_owner  out  selected requester (meaningful when grant_valid)
// ---------------------------------------------------------------------------
module rr_arb2
  import dmem_pkg::*;
(
  input  logic   req_cpu,
  input  logic   req_dma,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  // A lone request is granted directly; a tie goes to whoever waited last.
  always_comb begin
    grant_valid = req_cpu | req_dma;
    grant_owner = OWN_CPU;
    if (req_cpu && req_dma) begin
      grant_owner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (req_dma) begin
      grant_owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the CPU load/store path and the
// DMA engine. Each access is latched in IDLE, drives the memory enables for
// exactly one cycle in ACCESS, and is acknowledged with registered read data
// in RESP, giving one access every three cycles.
//
// Optional feature macro: DMEM_ARB_IO_PORTS_EN
//   When defined, addresses IN_PORT_ADDR / OUT_PORT_ADDR are decoded here as
//   an input port and an output port register instead of reaching memory.
//   When undefined, those addresses go to memory and reads of them return 0.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_cpu_req/addr/we/wdata        CPU request, held until out_cpu_ack
//   out_cpu_ack                     one-cycle CPU completion pulse
//   in_dma_req/addr/we/wdata        DMA request, held until out_dma_ack
//   out_dma_ack                     one-cycle DMA completion pulse
//   out_rdata                       read data, valid with the owner's ack
//   out_busy                        high in ACCESS and RESP
//   in_mem_rdata                    memory read data
//   in_port_data                    input port value (macro only)
//   out_port_data                   output port register (macro only)
//   out_port_strobe                 output port write pulse (macro only)
//   out_mem_addr/write_en/read_en/wdata   memory control
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_cpu_req,
  input  logic [ADDR_W-1:0] in_cpu_addr,
  input  logic              in_cpu_we,
  input  logic [DATA_W-1:0] in_cpu_wdata,
  output logic              out_cpu_ack,
  input  logic              in_dma_req,
  input  logic [ADDR_W-1:0] in_dma_addr,
  input  logic              in_dma_we,
  input  logic [DATA_W-1:0] in_dma_wdata,
  output logic              out_dma_ack,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_busy,
  input  logic [DATA_W-1:0] in_mem_rdata,
`ifdef DMEM_ARB_IO_PORTS_EN
  input  logic [DATA_W-1:0] in_port_data,
  output logic [DATA_W-1:0] out_port_data,
  output logic              out_port_strobe,
`endif
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_write_en,
  output logic              out_mem_read_en,
  output logic [DATA_W-1:0] out_mem_wdata
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  owner_t            owner_q;
  owner_t            last_owner_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_valid;
  owner_t            grant_owner;
  logic              is_in_port;
  logic              is_out_port;
  logic              io_hit;
  logic [DATA_W-1:0] read_value;

`ifdef DMEM_ARB_IO_PORTS_EN
  logic [DATA_W-1:0] port_data_q;
  logic              port_strobe_q;
`endif

  rr_arb2 u_rr_arb2 (
    .req_cpu     (in_cpu_req),
    .req_dma     (in_dma_req),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign is_in_port  = (addr_q == ADDR_W'(IN_PORT_ADDR));
  assign is_out_port = (addr_q == ADDR_W'(OUT_PORT_ADDR));

  // Port addresses are claimed by the arbiter itself when the I/O feature is
  // built in; otherwise they pass to memory, but the captured value is forced
  // to zero because the memory leaves its data bus floating for them.
`ifdef DMEM_ARB_IO_PORTS_EN
  assign io_hit     = is_in_port | is_out_port;
  assign read_value = is_in_port  ? in_port_data :
                      is_out_port ? port_data_q  : in_mem_rdata;
`else
  assign io_hit     = 1'b0;
  assign read_value = (is_in_port | is_out_port) ? '0 : in_mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and output decode. The write enable is additionally gated by
  // rst so an access interrupted by reset can never corrupt memory.
  always_comb begin
    state_d          = state_q;
    out_busy         = 1'b0;
    out_cpu_ack      = 1'b0;
    out_dma_ack      = 1'b0;
    out_mem_addr     = '0;
    out_mem_wdata    = '0;
    out_mem_write_en = 1'b0;
    out_mem_read_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ACCESS;
      end
      ACCESS: begin
        out_busy      = 1'b1;
        out_mem_addr  = addr_q;
        out_mem_wdata = wdata_q;
        if (!io_hit) begin
          out_mem_write_en = we_q & ~rst;
          out_mem_read_en  = ~we_q;
        end
        state_d = RESP;
      end
      RESP: begin
        out_busy    = 1'b1;
        out_cpu_ack = (owner_q == OWN_CPU);
        out_dma_ack = (owner_q == OWN_DMA);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, read capture and round-robin history. Request fields are
  // only looked at on the IDLE grant edge; last_owner moves at the end of
  // ACCESS so a dropped (reset) access does not disturb the rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      rdata_q      <= '0;
`ifdef DMEM_ARB_IO_PORTS_EN
      port_data_q   <= '0;
      port_strobe_q <= 1'b0;
`endif
    end else begin
`ifdef DMEM_ARB_IO_PORTS_EN
      port_strobe_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_owner;
            if (grant_owner == OWN_DMA) begin
              addr_q  <= in_dma_addr;
              we_q    <= in_dma_we;
              wdata_q <= in_dma_wdata;
            end else begin
              addr_q  <= in_cpu_addr;
              we_q    <= in_cpu_we;
              wdata_q <= in_cpu_wdata;
            end
          end
        end
        ACCESS: begin
          last_owner_q <= owner_q;
          if (!we_q) rdata_q <= read_value;
`ifdef DMEM_ARB_IO_PORTS_EN
          if (we_q && is_out_port) begin
            port_data_q   <= wdata_q;
            port_strobe_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_rdata = rdata_q;

`ifdef DMEM_ARB_IO_PORTS_EN
  assign out_port_data   = port_data_q;
  assign out_port_strobe = port_strobe_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural memory model and a
// scoreboard of expected acknowledgements (owner, read data, cycle).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_cpu_req = 1'b0;
  logic [9:0] in_cpu_addr = '0;
  logic       in_cpu_we = 1'b0;
  logic [7:0] in_cpu_wdata = '0;
  logic       out_cpu_ack;
  logic       in_dma_req = 1'b0;
  logic [9:0] in_dma_addr = '0;
  logic       in_dma_we = 1'b0;
  logic [7:0] in_dma_wdata = '0;
  logic       out_dma_ack;
  logic [7:0] out_rdata;
  logic       out_busy;
  logic [7:0] in_mem_rdata;
  logic [9:0] out_mem_addr;
  logic       out_mem_write_en;
  logic       out_mem_read_en;
  logic [7:0] out_mem_wdata;
`ifdef DMEM_ARB_IO_PORTS_EN
  logic [7:0] in_port_data = '0;
  logic [7:0] out_port_data;
  logic       out_port_strobe;
`endif

  int n_tests  = 0;
  int n_failed = 0;
  int cyc      = 0;

  typedef struct {
    logic       own_dma;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  // Memory model: untouched locations read as addr*3; the port addresses
  // are ignored by the memory and return a junk pattern instead of high-Z.
  logic [7:0] mem_data [0:1023];
  bit         mem_written [0:1023];

  function automatic logic [7:0] memRead(input logic [9:0] a);
    if (mem_written[a]) return mem_data[a];
    return 8'(a * 3);
  endfunction

  assign in_mem_rdata = (out_mem_read_en && out_mem_addr < 10'h3FE) ? memRead(out_mem_addr) : 8'hEE;

  always @(posedge clk) begin
    if (out_mem_write_en && out_mem_addr < 10'h3FE) begin
      mem_data[out_mem_addr]    <= out_mem_wdata;
      mem_written[out_mem_addr] <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .in_cpu_req       (in_cpu_req),
    .in_cpu_addr      (in_cpu_addr),
    .in_cpu_we        (in_cpu_we),
    .in_cpu_wdata     (in_cpu_wdata),
    .out_cpu_ack      (out_cpu_ack),
    .in_dma_req       (in_dma_req),
    .in_dma_addr      (in_dma_addr),
    .in_dma_we        (in_dma_we),
    .in_dma_wdata     (in_dma_wdata),
    .out_dma_ack      (out_dma_ack),
    .out_rdata        (out_rdata),
    .out_busy         (out_busy),
    .in_mem_rdata     (in_mem_rdata),
`ifdef DMEM_ARB_IO_PORTS_EN
    .in_port_data     (in_port_data),
    .out_port_data    (out_port_data),
    .out_port_strobe  (out_port_strobe),
`endif
    .out_mem_addr     (out_mem_addr),
    .out_mem_write_en (out_mem_write_en),
    .out_mem_read_en  (out_mem_read_en),
    .out_mem_wdata    (out_mem_wdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input logic own_dma, input logic [7:0] rdata, input int at_cyc);
    exp_t e;
    e.own_dma = own_dma;
    e.rdata   = rdata;
    e.cyc     = at_cyc;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic cr, input logic [9:0] ca, input logic cw, input logic [7:0] cd,
                               input logic dr, input logic [9:0] da, input logic dw, input logic [7:0] dd);
    in_cpu_req = cr; in_cpu_addr = ca; in_cpu_we = cw; in_cpu_wdata = cd;
    in_dma_req = dr; in_dma_addr = da; in_dma_we = dw; in_dma_wdata = dd;
  endtask

  // Returns at negedge+1 of the cycle carrying the n-th acknowledgement.
  task automatic waitAcks(input int n, input int budget);
    int seen = 0;
    int left = budget;
    while (seen < n && left > 0) begin
      @(negedge clk); #1;
      if (out_cpu_ack || out_dma_ack) seen++;
      left--;
    end
    if (seen < n) begin
      n_tests++;
      n_failed++;
      $display("[TB] FAIL ack_timeout: got %0d acks, expected %0d", seen, n);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 10'h0, 0, 8'h0, 0, 10'h0, 0, 8'h0);
    @(negedge clk);
    @(negedge clk); #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cpu_ack"}, 32'(out_cpu_ack), 0);
    checkOutput({tag, "_dma_ack"}, 32'(out_dma_ack), 0);
    checkOutput({tag, "_rdata"}, 32'(out_rdata), 0);
    checkOutput({tag, "_busy"}, 32'(out_busy), 0);
    checkOutput({tag, "_mem_addr"}, 32'(out_mem_addr), 0);
    checkOutput({tag, "_mem_we"}, 32'(out_mem_write_en), 0);
    checkOutput({tag, "_mem_re"}, 32'(out_mem_read_en), 0);
    checkOutput({tag, "_mem_wdata"}, 32'(out_mem_wdata), 0);
`ifdef DMEM_ARB_IO_PORTS_EN
    checkOutput({tag, "_port_data"}, 32'(out_port_data), 0);
    checkOutput({tag, "_port_strobe"}, 32'(out_port_strobe), 0);
`endif
  endtask

  // Monitor: every acknowledgement is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && (out_cpu_ack || out_dma_ack)) begin
      checkOutput("single_ack", 32'(out_cpu_ack & out_dma_ack), 0);
      if (sb.size() == 0) begin
        n_tests++;
        n_failed++;
        $display("[TB] FAIL unexpected_ack: got cpu=%0b dma=%0b, expected none", out_cpu_ack, out_dma_ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("ack_owner_dma", 32'(out_dma_ack), 32'(e.own_dma));
        checkOutput("ack_rdata", 32'(out_rdata), 32'(e.rdata));
        checkOutput("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;

    doReset();
    checkResetOutputs("reset");
    rst = 1'b0;

    // CPU write 0x5A to 0x010, then read it back.
    t0 = cyc;
    applyStimulus(1, 10'h010, 1, 8'h5A, 0, 10'h0, 0, 8'h0);
    pushExp(1'b0, 8'h00, t0 + 2);
    waitAcks(1, 10);
    applyStimulus(1, 10'h010, 0, 8'h00, 0, 10'h0, 0, 8'h0);
    pushExp(1'b0, 8'h5A, t0 + 5);
    waitAcks(1, 10);
    in_cpu_req = 1'b0;
    checkOutput("mem_010_written", 32'(memRead(10'h010)), 32'h5A);

    // Tie immediately after reset: CPU read 0x001 first, DMA write 0x002 next.
    doReset();
    rst = 1'b0;
    t0 = cyc;
    applyStimulus(1, 10'h001, 0, 8'h00, 1, 10'h002, 1, 8'h33);
    pushExp(1'b0, 8'h03, t0 + 2);
    pushExp(1'b1, 8'h03, t0 + 5);
    waitAcks(1, 10);
    in_cpu_req = 1'b0;
    waitAcks(1, 10);
    in_dma_req = 1'b0;
    checkOutput("mem_002_written", 32'(memRead(10'h002)), 32'h33);

    // Both requesters held high for eight accesses: strict alternation.
    @(negedge clk); #1;
    t0 = cyc;
    applyStimulus(1, 10'h010, 0, 8'h00, 1, 10'h002, 1, 8'h77);
    for (int i = 0; i < 8; i++) pushExp(1'(i % 2), 8'h5A, t0 + 2 + 3 * i);
    waitAcks(8, 40);
    applyStimulus(0, 10'h0, 0, 8'h0, 0, 10'h0, 0, 8'h0);
    checkOutput("mem_002_dma", 32'(memRead(10'h002)), 32'h77);

    // Reset during the ACCESS cycle of a DMA write: dropped, memory intact.
    @(negedge clk); #1;
    applyStimulus(0, 10'h0, 0, 8'h0, 1, 10'h020, 1, 8'hFF);
    @(negedge clk); #1;
    checkOutput("midop_we_before_rst", 32'(out_mem_write_en), 1);
    rst = 1'b1;
    #1;
    checkOutput("midop_we_gated", 32'(out_mem_write_en), 0);
    @(negedge clk); #1;
    checkResetOutputs("midop");
    checkOutput("mem_020_unchanged", 32'(memRead(10'h020)), 32'h60);
    rst = 1'b0;
    in_dma_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    // Ordinary read to load a non-zero value into out_rdata.
    t0 = cyc;
    applyStimulus(1, 10'h010, 0, 8'h00, 0, 10'h0, 0, 8'h0);
    pushExp(1'b0, 8'h5A, t0 + 2);
    waitAcks(1, 10);
    in_cpu_req = 1'b0;
    @(negedge clk); #1;

`ifdef DMEM_ARB_IO_PORTS_EN
    // Output port write: decoded locally, strobe in the ack cycle.
    t0 = cyc;
    applyStimulus(1, 10'h3FF, 1, 8'hA5, 0, 10'h0, 0, 8'h0);
    pushExp(1'b0, 8'h5A, t0 + 2);
    @(negedge clk); #1;
    checkOutput("port_wr_mem_we", 32'(out_mem_write_en), 0);
    checkOutput("port_wr_mem_re", 32'(out_mem_read_en), 0);
    waitAcks(1, 10);
    checkOutput("port_strobe_pulse", 32'(out_port_strobe), 1);
    checkOutput("port_data", 32'(out_port_data), 32'hA5);
    in_cpu_req = 1'b0;
    @(negedge clk); #1;
    checkOutput("port_strobe_end", 32'(out_port_strobe), 0);

    // Input port read.
    in_port_data = 8'h3C;
    t0 = cyc;
    applyStimulus(1, 10'h3FE, 0, 8'h00, 0, 10'h0, 0, 8'h0);
    pushExp(1'b0, 8'h3C, t0 + 2);
    @(negedge clk); #1;
    checkOutput("in_port_mem_re", 32'(out_mem_read_en), 0);
    waitAcks(1, 10);
    in_cpu_req = 1'b0;
    @(negedge clk); #1;

    // Output port read-back.
    t0 = cyc;
    applyStimulus(1, 10'h3FF, 0, 8'h00, 0, 10'h0, 0, 8'h0);
    pushExp(1'b0, 8'hA5, t0 + 2);
    waitAcks(1, 10);
    in_cpu_req = 1'b0;
`else
    // Read of 0x3FF goes to memory but returns zero, on time.
    t0 = cyc;
    applyStimulus(1, 10'h3FF, 0, 8'h00, 0, 10'h0, 0, 8'h0);
    pushExp(1'b0, 8'h00, t0 + 2);
    @(negedge clk); #1;
    checkOutput("port_addr_forwarded", 32'(out_mem_read_en), 1);
    waitAcks(1, 10);
    in_cpu_req = 1'b0;
`endif

    repeat (5) @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
